// File: rtl/lcd_init_seq_if.sv
// Byte-transfer bundle for the LCD init sequencer: the user request channel and the
// link to the SPI byte transmitter, including the panel D/C line.
//
// Handshakes: the user raises req with req_dc/req_data and holds all three until ack.
// ack is a one-cycle pulse. The sequencer raises spi_onoff with spi_data/dc already
// stable and holds them until spi_valid, which is a one-cycle completion pulse.
// spi_onoff then drops for at least one cycle before the next byte.
interface lcd_init_seq_if;
  logic       req;
  logic       req_dc;
  logic [7:0] req_data;
  logic       ack;
  logic       spi_onoff;
  logic [7:0] spi_data;
  logic       spi_valid;
  logic       dc;

  modport master (
    output req, req_dc, req_data, spi_valid,
    input  ack, spi_onoff, spi_data, dc
  );

  modport slave (
    input  req, req_dc, req_data, spi_valid,
    output ack, spi_onoff, spi_data, dc
  );
endinterface

// File: rtl/lcd_init_seq.sv
// LCD power-up sequencer: pulses the panel reset, replays a fixed command/data/delay ROM
// through the SPI byte transmitter, then serves single user bytes until restarted.
module lcd_init_seq #(
  parameter int unsigned RESET_CYCLES   = 5_000_000,
  parameter int unsigned RECOVER_CYCLES = 12_000_000,
  parameter int unsigned MS_CYCLES      = 100_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  lcd_init_seq_if.slave      bus,
  output logic               ready,
  output logic               busy,
  output logic               lcd_reset,
  output logic [3:0]         dbg_state
);

  typedef enum logic [3:0] {
    S_HW_RST  = 4'd0,
    S_HW_WAIT = 4'd1,
    S_FETCH   = 4'd2,
    S_SEND    = 4'd3,
    S_GAP     = 4'd4,
    S_DELAY   = 4'd5,
    S_READY   = 4'd6,
    S_USER    = 4'd7,
    S_UGAP    = 4'd8
  } state_t;

  localparam logic [1:0]  K_CMD   = 2'b00;
  localparam logic [1:0]  K_DATA  = 2'b01;
  localparam logic [1:0]  K_DELAY = 2'b10;
  localparam logic [1:0]  K_END   = 2'b11;

  localparam logic [31:0] RESET_LAST   = 32'(RESET_CYCLES - 1);
  localparam logic [31:0] RECOVER_LAST = 32'(RECOVER_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [31:0] cnt_q, cnt_d;
  logic        lcd_reset_q, lcd_reset_d;
  logic        onoff_q, onoff_d;
  logic [7:0]  data_q, data_d;
  logic        dc_q, dc_d;
  logic        ack_q, ack_d;

  logic [1:0]  rom_kind;
  logic [7:0]  rom_val;
  logic [31:0] dly_last;

  // Indices past the table read as END so a runaway index parks in READY.
  always_comb begin
    rom_kind = K_END;
    rom_val  = 8'h00;
    case (idx_q)
      4'd0:    begin rom_kind = K_CMD;   rom_val = 8'h01; end
      4'd1:    begin rom_kind = K_DELAY; rom_val = 8'd150; end
      4'd2:    begin rom_kind = K_CMD;   rom_val = 8'h11; end
      4'd3:    begin rom_kind = K_DELAY; rom_val = 8'd120; end
      4'd4:    begin rom_kind = K_CMD;   rom_val = 8'h3A; end
      4'd5:    begin rom_kind = K_DATA;  rom_val = 8'h55; end
      4'd6:    begin rom_kind = K_CMD;   rom_val = 8'h36; end
      4'd7:    begin rom_kind = K_DATA;  rom_val = 8'h00; end
      4'd8:    begin rom_kind = K_CMD;   rom_val = 8'h29; end
      4'd9:    begin rom_kind = K_DELAY; rom_val = 8'd20; end
      default: begin rom_kind = K_END;   rom_val = 8'h00; end
    endcase
  end

  assign dly_last = ({24'd0, rom_val} * MS_CYCLES) - 32'd1;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    lcd_reset_d = lcd_reset_q;
    onoff_d     = onoff_q;
    data_d      = data_q;
    dc_d        = dc_q;
    ack_d       = 1'b0;
    case (state_q)
      S_HW_RST: begin
        lcd_reset_d = 1'b0;
        if (cnt_q == RESET_LAST) begin
          cnt_d       = 32'd0;
          lcd_reset_d = 1'b1;
          state_d     = S_HW_WAIT;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_HW_WAIT: begin
        if (cnt_q == RECOVER_LAST) begin
          cnt_d   = 32'd0;
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_FETCH: begin
        case (rom_kind)
          K_CMD, K_DATA: begin
            dc_d    = (rom_kind == K_DATA);
            data_d  = rom_val;
            onoff_d = 1'b1;
            state_d = S_SEND;
          end
          K_DELAY: begin
            // A zero delay skips straight to the next fetch.
            if (rom_val == 8'd0) begin
              idx_d = idx_q + 4'd1;
            end else begin
              cnt_d   = 32'd0;
              state_d = S_DELAY;
            end
          end
          default: state_d = S_READY;
        endcase
      end
      S_SEND: begin
        if (bus.spi_valid) begin
          onoff_d = 1'b0;
          idx_d   = idx_q + 4'd1;
          state_d = S_GAP;
        end
      end
      S_GAP: state_d = S_FETCH;
      S_DELAY: begin
        if (cnt_q == dly_last) begin
          cnt_d   = 32'd0;
          idx_d   = idx_q + 4'd1;
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_READY: begin
        if (start) begin
          idx_d       = 4'd0;
          cnt_d       = 32'd0;
          lcd_reset_d = 1'b0;
          state_d     = S_HW_RST;
        end else if (bus.req) begin
          dc_d    = bus.req_dc;
          data_d  = bus.req_data;
          onoff_d = 1'b1;
          state_d = S_USER;
        end
      end
      S_USER: begin
        if (bus.spi_valid) begin
          onoff_d = 1'b0;
          ack_d   = 1'b1;
          state_d = S_UGAP;
        end
      end
      S_UGAP:  state_d = S_READY;
      default: state_d = S_HW_RST;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_HW_RST;
      idx_q       <= 4'd0;
      cnt_q       <= 32'd0;
      lcd_reset_q <= 1'b0;
      onoff_q     <= 1'b0;
      data_q      <= 8'h00;
      dc_q        <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      lcd_reset_q <= lcd_reset_d;
      onoff_q     <= onoff_d;
      data_q      <= data_d;
      dc_q        <= dc_d;
      ack_q       <= ack_d;
    end
  end

  assign bus.spi_onoff = onoff_q;
  assign bus.spi_data  = data_q;
  assign bus.dc        = dc_q;
  assign bus.ack       = ack_q;
  assign lcd_reset     = lcd_reset_q;
  assign ready         = (state_q == S_READY);
  assign busy          = ~ready;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_lcd_init_seq.sv
// Bench for lcd_init_seq: timeline model of the init ROM, randomized user traffic,
// spurious spi_valid noise, start/req collision and asynchronous reset mid-transfer.
module tb_lcd_init_seq;
  localparam int R   = 10;
  localparam int W   = 20;
  localparam int MS  = 5;
  localparam int LAT = 8;

  logic       clk;
  logic       reset;
  logic       start;
  logic       ready;
  logic       busy;
  logic       lcd_reset;
  logic [3:0] dbg_state;

  lcd_init_seq_if bus ();

  lcd_init_seq #(
    .RESET_CYCLES  (R),
    .RECOVER_CYCLES(W),
    .MS_CYCLES     (MS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bus      (bus),
    .ready    (ready),
    .busy     (busy),
    .lcd_reset(lcd_reset),
    .dbg_state(dbg_state)
  );

  int         errors = 0;
  int         checks = 0;
  bit         noise_en = 0;
  bit         rand_lat = 0;
  int         last_lat = LAT;
  int         rom_kind [12];
  int         rom_val  [12];
  logic [8:0] exp_q [$];
  int         exp_t [$];

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SPI transmitter model: completes a byte LAT cycles (or a random latency) after enable rises.
  initial begin
    int cnt;
    int lat;
    cnt = 0;
    lat = LAT;
    bus.spi_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (reset || bus.spi_onoff !== 1'b1) begin
        cnt = 0;
        bus.spi_valid = noise_en && !reset && ($urandom_range(0, 3) == 0);
      end else begin
        if (cnt == 0) begin
          lat = rand_lat ? $urandom_range(2, 10) : LAT;
          last_lat = lat;
        end
        cnt++;
        bus.spi_valid = (cnt == lat);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_rom();
    int k [12] = '{0, 2, 0, 2, 0, 1, 0, 1, 0, 2, 3, 3};
    int v [12] = '{8'h01, 150, 8'h11, 120, 8'h3A, 8'h55, 8'h36, 8'h00, 8'h29, 20, 0, 0};
    for (int i = 0; i < 12; i++) begin
      rom_kind[i] = k[i];
      rom_val[i]  = v[i];
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if (lcd_reset !== 1'b0)
      $display("FAIL reset_lcd_reset: got %b expected 0", lcd_reset);
    if (lcd_reset !== 1'b0) errors++;
    checks++;
    if (bus.spi_onoff !== 1'b0 || bus.spi_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_spi: got onoff=%b data=%h expected 0/00", bus.spi_onoff, bus.spi_data);
    end
    checks++;
    if (bus.dc !== 1'b0 || bus.ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_dc_ack: got dc=%b ack=%b expected 0/0", bus.dc, bus.ack);
    end
    checks++;
    if (ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_busy: got %b/%b expected 0/1", ready, busy);
    end
  endtask

  // Follows one full init run; tick 0 is the reset release (off=0) or the start request (off=1).
  task automatic watch_init(input int off, input bit pulse_req);
    int         lr_rise = -1, ready_t = -1, exp_ready = -1;
    int         acks = 0, unstable = 0, relow = 0, f, p_at, p_len;
    bit         seen_low = 0, prev_on = 0;
    logic [8:0] hold = '0;
    int         rise_t [$];
    logic [8:0] got_q [$];

    exp_q.delete();
    exp_t.delete();
    f = off + R + W;
    for (int i = 0; i < 12; i++) begin
      if (rom_kind[i] <= 1) begin
        exp_q.push_back({(rom_kind[i] == 1), 8'(rom_val[i])});
        exp_t.push_back(f + 1);
        f = f + 1 + LAT + 1;
      end else if (rom_kind[i] == 2) begin
        f = f + 1 + rom_val[i] * MS;
      end else begin
        exp_ready = f + 1;
        break;
      end
    end

    noise_en = 1;
    rand_lat = 0;
    p_at  = off + R + 5;
    p_len = $urandom_range(1, 6);
    for (int n = 1; n <= 3000 && ready_t < 0; n++) begin
      if (pulse_req && n == p_at) begin
        bus.req      = 1'b1;
        bus.req_dc   = 1'($urandom);
        bus.req_data = 8'($urandom);
      end
      if (pulse_req && n == p_at + p_len) bus.req = 1'b0;
      tick();
      if (off == 1 && n == 1) begin
        checks++;
        if (lcd_reset !== 1'b0 || ready !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL start_wins: got lcd_reset=%b ready=%b busy=%b expected 0/0/1",
                   lcd_reset, ready, busy);
        end
        start   = 1'b0;
        bus.req = 1'b0;
      end
      if (lcd_reset !== 1'b1) begin
        if (lr_rise >= 0) relow++;
        seen_low = 1;
      end else if (seen_low && lr_rise < 0) begin
        lr_rise = n;
      end
      if (bus.spi_onoff === 1'b1 && !prev_on) begin
        hold = {bus.dc, bus.spi_data};
        rise_t.push_back(n);
        got_q.push_back(hold);
      end else if (bus.spi_onoff === 1'b1 && {bus.dc, bus.spi_data} !== hold) begin
        unstable++;
      end
      if (bus.ack === 1'b1) acks++;
      if (ready === 1'b1) ready_t = n;
      prev_on = (bus.spi_onoff === 1'b1);
    end
    bus.req = 1'b0;

    checks++;
    if (lr_rise != off + R) begin
      errors++;
      $display("FAIL lcd_reset_rise: got tick %0d expected %0d", lr_rise, off + R);
    end
    checks++;
    if (relow != 0) begin
      errors++;
      $display("FAIL lcd_reset_relow: got %0d low ticks after release expected 0", relow);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL init_byte_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL init_byte[%0d]: got dc/data=%h expected %h", i, got_q[i], exp_q[i]);
      end
      checks++;
      if (rise_t[i] != exp_t[i]) begin
        errors++;
        $display("FAIL init_rise_time[%0d]: got tick %0d expected %0d", i, rise_t[i], exp_t[i]);
      end
    end
    exp_q.delete();
    checks++;
    if (unstable != 0) begin
      errors++;
      $display("FAIL init_stable: got %0d changes while enabled expected 0", unstable);
    end
    checks++;
    if (acks != 0) begin
      errors++;
      $display("FAIL init_no_ack: got %0d ack cycles expected 0", acks);
    end
    checks++;
    if (ready_t != exp_ready) begin
      errors++;
      $display("FAIL ready_rise: got tick %0d expected %0d", ready_t, exp_ready);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL ready_busy: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_power_up();
    reset = 1'b0;
    watch_init(0, 1'b0);
  endtask

  task automatic test_user_bytes();
    int         nb = $urandom_range(3, 6);
    int         t, unstable, on_seen;
    logic [8:0] cur, want;
    noise_en = 1;
    rand_lat = 1;
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL user_entry_ready: got %b expected 1", ready);
    end
    cur = 9'($urandom);
    bus.req      = 1'b1;
    bus.req_dc   = cur[8];
    bus.req_data = cur[7:0];
    exp_q.push_back(cur);
    for (int b = 0; b < nb; b++) begin
      t = 0;
      while (bus.spi_onoff !== 1'b1 && t < 40) begin
        tick();
        t++;
      end
      checks++;
      if (t != 1) begin
        errors++;
        $display("FAIL user_rise_latency[%0d]: got %0d cycles expected 1", b, t);
      end
      want = exp_q.pop_front();
      checks++;
      if ({bus.dc, bus.spi_data} !== want) begin
        errors++;
        $display("FAIL user_byte[%0d]: got dc/data=%h expected %h", b, {bus.dc, bus.spi_data}, want);
      end
      checks++;
      if (ready !== 1'b0) begin
        errors++;
        $display("FAIL user_ready_low[%0d]: got %b expected 0", b, ready);
      end
      t = 0;
      unstable = 0;
      while (bus.ack !== 1'b1 && t < 40) begin
        tick();
        t++;
        if (bus.spi_onoff === 1'b1 && {bus.dc, bus.spi_data} !== want) unstable++;
      end
      checks++;
      if (t != last_lat) begin
        errors++;
        $display("FAIL user_ack_time[%0d]: got %0d cycles expected %0d", b, t, last_lat);
      end
      checks++;
      if (unstable != 0) begin
        errors++;
        $display("FAIL user_stable[%0d]: got %0d changes expected 0", b, unstable);
      end
      if (b < nb - 1) begin
        cur = 9'($urandom);
        bus.req_dc   = cur[8];
        bus.req_data = cur[7:0];
        exp_q.push_back(cur);
      end else begin
        bus.req = 1'b0;
      end
      tick();
      checks++;
      if (bus.ack !== 1'b0) begin
        errors++;
        $display("FAIL user_ack_width[%0d]: got %b expected 0", b, bus.ack);
      end
    end
    on_seen = 0;
    repeat (6) begin
      tick();
      if (bus.spi_onoff === 1'b1 || bus.ack === 1'b1) on_seen++;
    end
    checks++;
    if (on_seen != 0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL user_idle: got %0d active cycles ready=%b expected 0/1", on_seen, ready);
    end
  endtask

  task automatic test_start_collision();
    start        = 1'b1;
    bus.req      = 1'b1;
    bus.req_dc   = 1'($urandom);
    bus.req_data = 8'($urandom);
    watch_init(1, 1'b1);
  endtask

  task automatic test_reset_mid();
    int t = 0;
    rand_lat     = 1;
    bus.req      = 1'b1;
    bus.req_dc   = 1'($urandom);
    bus.req_data = 8'($urandom);
    while (bus.spi_onoff !== 1'b1 && t < 20) begin
      tick();
      t++;
    end
    checks++;
    if (bus.spi_onoff !== 1'b1) begin
      errors++;
      $display("FAIL midreset_setup: got onoff=%b expected 1", bus.spi_onoff);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.spi_onoff !== 1'b0 || lcd_reset !== 1'b0) begin
      errors++;
      $display("FAIL midreset_immediate: got onoff=%b lcd_reset=%b expected 0/0",
               bus.spi_onoff, lcd_reset);
    end
    checks++;
    if (bus.spi_data !== 8'h00 || bus.dc !== 1'b0 || bus.ack !== 1'b0 || ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midreset_values: got data=%h dc=%b ack=%b ready=%b busy=%b expected 00/0/0/0/1",
               bus.spi_data, bus.dc, bus.ack, ready, busy);
    end
    tick();
    bus.req = 1'b0;
    reset   = 1'b0;
    watch_init(0, 1'b0);
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    bus.req      = 1'b0;
    bus.req_dc   = 1'b0;
    bus.req_data = 8'h00;
    load_rom();
    test_reset();
    test_power_up();
    test_user_bytes();
    test_start_collision();
    test_user_bytes();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcd_init_seq.md
# lcd_init_seq

Sequencer for the SPI LCD panel. Drives the panel hardware reset and walks a fixed internal command ROM (commands, parameter bytes, millisecond delays), issuing each byte through the SPI byte transmitter via its `onoff`/`data_in`/`valid` handshake. After initialisation it hands the transmitter to a single user requester, and it re-runs the full sequence on demand.

## Interface
Parameters:
- `RESET_CYCLES`, default 5_000_000: number of cycles `lcd_reset` is held low.
- `RECOVER_CYCLES`, default 12_000_000: number of cycles waited after `lcd_reset` is released.
- `MS_CYCLES`, default 100_000: number of cycles per delay unit (1 ms at 100 MHz).

Ports:
- `clk` in 1: the single clock. All logic is rising-edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse that re-runs the full init sequence. Honoured only in READY.
- `req` in 1: level-sensitive user byte request.
- `req_dc` in 1: D/C value for the user byte.
- `req_data` in 8: the user byte.
- `ack` out 1: one-cycle pulse when the user byte has been sent.
- `ready` out 1: high in READY only.
- `busy` out 1: equal to `!ready`.
- `spi_onoff` out 1: transmit enable to the SPI transmitter.
- `spi_data` out 8: byte to the SPI transmitter.
- `spi_valid` in 1: one-cycle pulse from the transmitter when the byte is complete.
- `dc` out 1: panel D/C line (0 = command, 1 = data).
- `lcd_reset` out 1: panel reset, active-low.

## Operation
- Reset values:
  - `lcd_reset`=0, `spi_onoff`=0, `spi_data`=0, `dc`=0, `ack`=0, `ready`=0, `busy`=1.
  - State is HW_RST; ROM index is 0; counters are 0.
- States:
  - **HW_RST:** `lcd_reset`=0 for RESET_CYCLES cycles, then go to HW_WAIT.
  - **HW_WAIT:** `lcd_reset`=1 for RECOVER_CYCLES cycles, then go to FETCH.
  - **FETCH:** read ROM[idx] (1 cycle).
    - Kind CMD: `dc`=0, go to SEND.
    - Kind DATA: `dc`=1, go to SEND.
    - Kind DELAY: go to DELAY.
    - Kind END: go to READY.
  - **SEND:** `spi_data`=value and `spi_onoff`=1. Hold both until `spi_valid` is sampled high. In that same edge, `spi_onoff`←0, idx++, and go to GAP.
  - **GAP:** 1 cycle with `spi_onoff`=0, then go to FETCH. This guarantees the transmitter sees the enable drop between bytes.
  - **DELAY:** wait value×MS_CYCLES cycles, then idx++ and go to FETCH.
    - A value of 0 means idx++ and FETCH on the next cycle.
    - Internal cycle counter is 32 bits.
  - **READY:** `ready`=1.
    - `start`=1: idx←0, go to HW_RST.
    - Otherwise, `req`=1: latch `req_dc`→`dc` and `req_data`→`spi_data`, go to USER.
  - **USER:** `spi_onoff`=1 until `spi_valid`. On that edge, `spi_onoff`←0 and `ack`←1 for one cycle, then go to UGAP.
  - **UGAP:** 1 cycle, then go to READY.
- ROM format: 12 entries, each {kind[1:0], value[7:0]}. Kinds: 00 CMD, 01 DATA, 10 DELAY, 11 END. Fixed contents, in order:

  | idx | kind | value |
  |---|---|---|
  | 0 | CMD | 0x01 |
  | 1 | DELAY | 150 |
  | 2 | CMD | 0x11 |
  | 3 | DELAY | 120 |
  | 4 | CMD | 0x3A |
  | 5 | DATA | 0x55 |
  | 6 | CMD | 0x36 |
  | 7 | DATA | 0x00 |
  | 8 | CMD | 0x29 |
  | 9 | DELAY | 20 |
  | 10 | END | – |
  | 11 | END | – |

- Boundary rules:
  - `req` outside READY is ignored and not queued. The requester holds `req` until `ack`.
  - If `req` is still high in READY after UGAP, the next byte is sent. Maximum throughput is one byte per transfer + 2 cycles.
  - `start` and `req` in the same READY cycle: `start` wins and no `ack` is given.
  - `start` outside READY is ignored.
  - `spi_valid` outside SEND/USER is ignored.
  - `reset` mid-transfer returns the block to its reset values immediately, including `spi_onoff`=0 and `lcd_reset`=0.
  - `spi_data` and `dc` are stable for the whole time `spi_onoff` is high.

## Timing
- From the release of `reset` (or from the `start` edge):
  - `lcd_reset` stays low exactly RESET_CYCLES cycles.
  - It then stays high RECOVER_CYCLES cycles before the first FETCH.
- The first `spi_onoff` rise comes 2 cycles after HW_WAIT ends (FETCH, then SEND).
- Byte-to-byte gap between a `spi_valid` edge and the next `spi_onoff` rise is 3 cycles (GAP, FETCH, SEND).
- A DELAY entry adds value×MS_CYCLES + 1 (FETCH) cycles.
- USER transfers:
  - `spi_onoff` rises 1 cycle after `req` is sampled in READY.
  - `ack` is high in the cycle after `spi_valid`.
- `ready` rises the cycle after the END entry is fetched.

## Test plan
Bench parameters: RESET_CYCLES=10, RECOVER_CYCLES=20, MS_CYCLES=5. The SPI model returns `spi_valid` 8 cycles after `spi_onoff` rises.

- **Power-up:** release `reset`. Expect:
  - `lcd_reset` low for 10 cycles, then high.
  - The first byte 0x01 with `dc`=0 after 20 more cycles + 2.
- **Full sequence:** check the byte/D/C order 01/0, 11/0, 3A/0, 55/1, 36/0, 00/1, 29/0.
  - Check the delay gaps of 750, 600 and 100 cycles.
  - Check that `ready` rises after the last delay.
- **User byte:** in READY, `req`=1, `req_dc`=1, `req_data`=0xA5. Expect:
  - `spi_onoff`=1 with 0xA5 and `dc`=1.
  - One `ack` pulse.
  - Holding `req` high gives back-to-back sends.
- **Request during init:** pulse `req` during HW_WAIT. Expect no `ack` and no `spi_onoff` outside the sequence.
- **Start vs req collision:** `start`=1 and `req`=1 in the same READY cycle. Expect:
  - `lcd_reset` goes low the next cycle and `ready`=0.
  - No `ack` is given.
- **Reset mid-transfer:** assert `reset` while `spi_onoff`=1. Expect `spi_onoff`=0 and `lcd_reset`=0 immediately, and the sequence restarts from idx 0.
